// File: rtl/wbm_req_queue.sv
// Wishbone master front-end: queues valid/ready memory requests in a small FIFO and
// runs one single-beat Wishbone cycle per request, returning data/completion/timeout.
module wbm_req_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_data_i,
    input  logic [7:0]  req_sel_i,
    input  logic        req_we_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_we_o,
    output logic        rsp_err_o,
    output logic [63:0] wbm_addr_o,
    output logic [63:0] wbm_data_o,
    input  logic [63:0] wbm_data_i,
    output logic [7:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cycle_o,
    output logic        wbm_strobe_o,
    input  logic        wbm_ack_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DRAIN, S_RESP} state_e;

    logic [63:0] fifo_addr_q [DEPTH];
    logic [63:0] fifo_data_q [DEPTH];
    logic [7:0]  fifo_sel_q  [DEPTH];
    logic        fifo_we_q   [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ready_q;
    logic                  push, pop;

    state_e      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    assign push = req_valid_i && ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; only pointers and count define the FIFO contents.
    always_ff @(posedge sys_clock_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= req_addr_i;
            fifo_data_q[wr_ptr_q] <= req_data_i;
            fifo_sel_q[wr_ptr_q]  <= req_sel_i;
            fifo_we_q[wr_ptr_q]   <= req_we_i;
        end
    end

    // Ready is registered from the next count so it is low in reset and never
    // reacts combinationally to the pop in the same cycle.
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cyc_d       = cyc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        we_d        = we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (count_q != '0) begin
                    addr_d  = fifo_addr_q[rd_ptr_q];
                    wdata_d = fifo_data_q[rd_ptr_q];
                    sel_d   = fifo_sel_q[rd_ptr_q];
                    we_d    = fifo_we_q[rd_ptr_q];
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    rsp_data_d = we_q ? 64'd0 : wbm_data_i;
                    rsp_we_d   = we_q;
                    rsp_err_d  = 1'b0;
                    cyc_d      = 1'b0;
                    state_d    = S_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = 64'd0;
                    rsp_we_d   = we_q;
                    rsp_err_d  = 1'b1;
                    cyc_d      = 1'b0;
                    state_d    = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            // One dead cycle swallows a possible late re-ack from the registered slave.
            S_DRAIN: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            cyc_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_we_o     = rsp_we_q;
    assign rsp_err_o    = rsp_err_q;
    assign wbm_addr_o   = addr_q;
    assign wbm_data_o   = wdata_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_we_o     = we_q;
    assign wbm_cycle_o  = cyc_q;
    assign wbm_strobe_o = cyc_q;

endmodule

// File: tb/tb_wbm_req_queue.sv
// Directed bench for wbm_req_queue against a registered-ack 64-bit memory slave model.
module tb_wbm_req_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr = '0, req_data = '0;
    logic [7:0]  req_sel = '0;
    logic        req_we = 1'b0;
    logic        rsp_valid_o, rsp_we_o, rsp_err_o;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data_o;
    logic [63:0] wbm_addr_o, wbm_data_o;
    logic [63:0] slv_rdata;
    logic [7:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cycle_o, wbm_strobe_o;
    logic        slv_ack;
    logic        slv_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int cyc_rises = 0;
    logic cyc_prev = 1'b0;

    logic [63:0] slv_mem [256];
    logic [63:0] ref_mem [256];
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    wbm_req_queue #(.DEPTH_LOG2(2), .TIMEOUT(16)) dut (
        .sys_clock_i(clk), .sys_reset_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_sel_i(req_sel), .req_we_i(req_we),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
        .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_data_i(slv_rdata),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cycle_o(wbm_cycle_o), .wbm_strobe_o(wbm_strobe_o), .wbm_ack_i(slv_ack)
    );

    // Registered slave: acks every cycle it sees STB, so it re-acks once after STB drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_ack   <= 1'b0;
            slv_rdata <= '0;
            for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
        end else begin
            slv_ack <= slv_en && wbm_cycle_o && wbm_strobe_o;
            if (slv_en && wbm_cycle_o && wbm_strobe_o) begin
                if (wbm_we_o) begin
                    for (int b = 0; b < 8; b++)
                        if (wbm_sel_o[b]) slv_mem[wbm_addr_o[10:3]][b*8 +: 8] <= wbm_data_o[b*8 +: 8];
                end else begin
                    slv_rdata <= slv_mem[wbm_addr_o[10:3]];
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc_prev <= wbm_cycle_o;
        if (wbm_cycle_o && !cyc_prev) cyc_rises <= cyc_rises + 1;
        if (rst_n && wbm_cycle_o && slv_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] data, input logic [7:0] sel);
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_sel = sel;
        for (int n = 0; n < 200; n++) begin
            if (req_ready_o) ok = 1'b1;
            tick();
            if (ok) break;
        end
        req_valid = 1'b0;
        chk1({tag, "_accept"}, ok, 1'b1);
    endtask

    task automatic get_rsp(input string tag, input logic [63:0] data, input logic we, input logic err);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (rsp_valid_o) begin ok = 1'b1; break; end
            tick();
        end
        chk1({tag, "_rsp_seen"}, ok, 1'b1);
        if (ok) begin
            chk({tag, "_data"}, rsp_data_o, data);
            chk1({tag, "_we"}, rsp_we_o, we);
            chk1({tag, "_err"}, rsp_err_o, err);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk1({tag, "_valid_drop"}, rsp_valid_o, 1'b0);
        end
        $display("rsp %s: data=%h we=%b err=%b", tag, rsp_data_o, rsp_we_o, rsp_err_o);
    endtask

    initial begin
        int r0, a0, n, hi, cnt;
        logic ok;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_ready", req_ready_o, 1'b0);
        chk1("rst_cyc", wbm_cycle_o, 1'b0);
        chk1("rst_stb", wbm_strobe_o, 1'b0);
        chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_addr", wbm_addr_o, 64'd0);
        chk("rst_rsp_data", rsp_data_o, 64'd0);
        rst_n = 1'b1;
        tick();
        chk1("ready_after_rst", req_ready_o, 1'b1);

        // 1: write then read, with latency and bus-field checks on the write
        push("t1_w", 1'b1, 64'h40, 64'h1122334455667788, 8'hFF);
        chk1("t1_lat_e0_cyc", wbm_cycle_o, 1'b0);
        tick();
        chk1("t1_lat_e1_cyc", wbm_cycle_o, 1'b1);
        chk1("t1_lat_e1_stb", wbm_strobe_o, 1'b1);
        chk("t1_bus_addr", wbm_addr_o, 64'h40);
        chk("t1_bus_data", wbm_data_o, 64'h1122334455667788);
        chk("t1_bus_sel", 64'(wbm_sel_o), 64'hFF);
        chk1("t1_bus_we", wbm_we_o, 1'b1);
        tick();
        chk1("t1_lat_e2_cyc", wbm_cycle_o, 1'b1);
        tick();
        chk1("t1_lat_e3_cyc", wbm_cycle_o, 1'b0);
        chk1("t1_lat_e3_valid", rsp_valid_o, 1'b0);
        tick();
        chk1("t1_lat_e4_valid", rsp_valid_o, 1'b1);
        get_rsp("t1_w", 64'd0, 1'b1, 1'b0);
        push("t1_r", 1'b0, 64'h40, 64'd0, 8'hFF);
        get_rsp("t1_r", 64'h1122334455667788, 1'b0, 1'b0);

        // 2: partial-lane write
        push("t2_w", 1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        get_rsp("t2_w", 64'd0, 1'b1, 1'b0);
        push("t2_r", 1'b0, 64'h40, 64'd0, 8'hFF);
        get_rsp("t2_r", 64'h11223344AAAAAAAA, 1'b0, 1'b0);

        // 3: fill FIFO while the response is held off
        r0 = cyc_rises;
        push("t3_1", 1'b1, 64'h100, 64'h0123456789ABCDEF, 8'hFF);
        push("t3_2", 1'b0, 64'h100, 64'd0, 8'hFF);
        push("t3_3", 1'b1, 64'h108, 64'hFEDCBA9876543210, 8'hF0);
        push("t3_4", 1'b0, 64'h108, 64'd0, 8'hFF);
        push("t3_5", 1'b0, 64'h40, 64'd0, 8'hFF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h40;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) hi++;
            tick();
        end
        req_valid = 1'b0;
        chk("t3_ready_high_cycles", 64'(hi), 64'd0);
        chk("t3_bus_cycles", 64'(cyc_rises - r0), 64'd1);
        get_rsp("t3_1", 64'd0, 1'b1, 1'b0);
        get_rsp("t3_2", 64'h0123456789ABCDEF, 1'b0, 1'b0);
        get_rsp("t3_3", 64'd0, 1'b1, 1'b0);
        get_rsp("t3_4", 64'hFEDCBA9800000000, 1'b0, 1'b0);
        get_rsp("t3_5", 64'h11223344AAAAAAAA, 1'b0, 1'b0);

        // 4: timeout with slave silent
        slv_en = 1'b0;
        push("t4_r", 1'b0, 64'h40, 64'd0, 8'hFF);
        ok = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (wbm_cycle_o) begin ok = 1'b1; break; end
            tick();
        end
        chk1("t4_cyc_start", ok, 1'b1);
        cnt = 0;
        for (n = 0; n < 100 && wbm_cycle_o; n++) begin
            cnt++;
            tick();
        end
        chk("t4_cyc_len", 64'(cnt), 64'd16);
        get_rsp("t4_r", 64'd0, 1'b0, 1'b1);
        slv_en = 1'b1;
        push("t4_r2", 1'b0, 64'h40, 64'd0, 8'hFF);
        get_rsp("t4_r2", 64'h11223344AAAAAAAA, 1'b0, 1'b0);

        // 5: reset in the middle of a bus cycle with a second request queued
        push("t5_r", 1'b0, 64'h48, 64'd0, 8'hFF);
        push("t5_w", 1'b1, 64'h50, 64'h5555, 8'hFF);
        chk1("t5_in_bus", wbm_cycle_o, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("t5_async_cyc", wbm_cycle_o, 1'b0);
        chk1("t5_async_stb", wbm_strobe_o, 1'b0);
        chk1("t5_async_valid", rsp_valid_o, 1'b0);
        chk1("t5_async_ready", req_ready_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = cyc_rises;
        cnt = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid_o) cnt++;
            tick();
        end
        rsp_ready = 1'b0;
        chk("t5_stale_rsp", 64'(cnt), 64'd0);
        chk("t5_stale_cyc", 64'(cyc_rises - r0), 64'd0);
        chk1("t5_ready_after", req_ready_o, 1'b1);

        // 6: 100 random back-to-back requests against the reference memory
        r0 = cyc_rises;
        a0 = ack_cnt;
        fork
            begin : producer
                for (int i = 0; i < 100; i++) begin
                    logic        we;
                    logic [7:0]  idx, sel;
                    logic [63:0] d;
                    we  = 1'($urandom_range(0, 1));
                    idx = 8'd128 + 8'($urandom_range(0, 7));
                    sel = 8'($urandom);
                    d   = {$urandom, $urandom};
                    if (we) begin
                        for (int b = 0; b < 8; b++)
                            if (sel[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
                        exp_q.push_back({1'b1, 64'd0});
                    end else begin
                        exp_q.push_back({1'b0, ref_mem[idx]});
                    end
                    push("t6_push", we, {53'd0, idx, 3'd0}, d, sel);
                end
            end
            begin : consumer
                int got;
                logic [64:0] e;
                got = 0;
                for (int k = 0; k < 20000 && got < 100; k++) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    if (rsp_valid_o && rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("t6_unexpected_rsp", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("t6_data", rsp_data_o, e[63:0]);
                            chk1("t6_we", rsp_we_o, e[64]);
                            chk1("t6_err", rsp_err_o, 1'b0);
                            $display("t6 rsp %0d: we=%b data=%h", got, rsp_we_o, rsp_data_o);
                        end
                        got++;
                    end
                    tick();
                end
                rsp_ready = 1'b0;
                chk("t6_rsp_count", 64'(got), 64'd100);
            end
        join
        repeat (3) tick();
        chk("t6_ack_edges", 64'(ack_cnt - a0), 64'd100);
        chk("t6_bus_cycles", 64'(cyc_rises - r0), 64'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
